// File: rtl/serializer_sequencer.sv
// Frame sequencer for a two-word serial link: issues Load/Shift pulses to an
// external shift register and generates SClk plus a Frame strobe.
module serializer_sequencer #(
  parameter int NumbDataBits = 8,
  parameter int ClkDiv       = 4
) (
  input  logic Clk,
  input  logic Clr,
  input  logic Start,
  output logic Load,
  output logic Shift,
  output logic SClk,
  output logic Frame,
  output logic Busy,
  output logic Done
);

  localparam int BitW = $clog2(2 * NumbDataBits);
  localparam int DivW = $clog2(ClkDiv);
  localparam logic [BitW-1:0] BitLast = BitW'(2 * NumbDataBits - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t          r_state;
  logic [BitW-1:0] r_bitCount;
  logic [DivW-1:0] r_divCount;

  // Every output is a register updated alongside the state, so Start never
  // reaches an output combinationally and pulses line up with their states.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_state    <= IDLE;
      r_bitCount <= '0;
      r_divCount <= '0;
      Load       <= 1'b0;
      Shift      <= 1'b0;
      SClk       <= 1'b0;
      Frame      <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      Load  <= 1'b0;
      Shift <= 1'b0;
      Done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_state <= LOAD;
            Load    <= 1'b1;
            Frame   <= 1'b1;
            Busy    <= 1'b1;
          end
        end
        LOAD: begin
          r_state    <= LOW;
          r_bitCount <= '0;
          r_divCount <= '0;
          SClk       <= 1'b0;
        end
        LOW: begin
          if (r_divCount == DivLast) begin
            r_divCount <= '0;
            r_state    <= HIGH;
            SClk       <= 1'b1;
          end else begin
            r_divCount <= r_divCount + 1'b1;
          end
        end
        HIGH: begin
          if (r_divCount == DivLast) begin
            r_divCount <= '0;
            SClk       <= 1'b0;
            // The last bit ends the frame without a Shift pulse.
            if (r_bitCount == BitLast) begin
              r_state <= DONE;
              Frame   <= 1'b0;
              Done    <= 1'b1;
            end else begin
              r_bitCount <= r_bitCount + 1'b1;
              r_state    <= LOW;
              Shift      <= 1'b1;
            end
          end else begin
            r_divCount <= r_divCount + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          Busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          SClk    <= 1'b0;
          Frame   <= 1'b0;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_sequencer.sv
// Directed bench for serializer_sequencer: a default (8 bits, div 4) instance
// and a minimum (1 bit, div 2) instance, each driving a small shift-register model.
module tb_serializer_sequencer;

  logic Clk = 1'b0;
  logic Clr;
  logic start;
  logic sel;

  logic startA, aLoad, aShift, aSClk, aFrame, aBusy, aDone;
  logic startB, bLoad, bShift, bSClk, bFrame, bBusy, bDone;
  logic mLoad, mShift, mSClk, mFrame, mBusy, mDone;

  int nPass  = 0;
  int nTotal = 0;

  // Per-window observations gathered by watch
  int loadCnt, shiftCnt, riseCnt, doneCnt, overlap;
  int doneRel, frameFirst, frameLast, busyLast, lastShiftRel, minGap;
  int loadRels[$];
  logic [15:0] bits;
  logic [15:0] sr;
  logic prevSClk;

  always #5 Clk = ~Clk;

  assign startA = sel ? 1'b0 : start;
  assign startB = sel ? start : 1'b0;

  assign mLoad  = sel ? bLoad  : aLoad;
  assign mShift = sel ? bShift : aShift;
  assign mSClk  = sel ? bSClk  : aSClk;
  assign mFrame = sel ? bFrame : aFrame;
  assign mBusy  = sel ? bBusy  : aBusy;
  assign mDone  = sel ? bDone  : aDone;

  serializer_sequencer #(.NumbDataBits(8), .ClkDiv(4)) dutA (
    .Clk(Clk), .Clr(Clr), .Start(startA), .Load(aLoad), .Shift(aShift),
    .SClk(aSClk), .Frame(aFrame), .Busy(aBusy), .Done(aDone)
  );

  serializer_sequencer #(.NumbDataBits(1), .ClkDiv(2)) dutB (
    .Clk(Clk), .Clr(Clr), .Start(startB), .Load(bLoad), .Shift(bShift),
    .SClk(bSClk), .Frame(bFrame), .Busy(bBusy), .Done(bDone)
  );

  // External shift register: captures A5_3C (or 2'b10 for the 1-bit instance)
  // on Load and presents its MSB one cycle late, shifting left on Shift.
  always @(posedge Clk) begin
    if (mLoad) sr <= sel ? 16'h8000 : 16'hA53C;
    else if (mShift) sr <= {sr[14:0], 1'b0};
  end

  task automatic watch(input int n, input int startOff, input int p1, input int p2);
    loadCnt = 0; shiftCnt = 0; riseCnt = 0; doneCnt = 0; overlap = 0;
    doneRel = -1; frameFirst = -1; frameLast = -1; busyLast = -1;
    lastShiftRel = -1000; minGap = 1000; bits = '0;
    loadRels.delete();
    prevSClk = mSClk;
    for (int i = 1; i <= n; i++) begin
      @(negedge Clk);
      if (mLoad) begin loadCnt++; loadRels.push_back(i); end
      if (mShift) begin shiftCnt++; lastShiftRel = i; end
      if (mLoad && mShift) overlap++;
      if (mDone) begin doneCnt++; if (doneRel < 0) doneRel = i; end
      if (mFrame) begin if (frameFirst < 0) frameFirst = i; frameLast = i; end
      if (mBusy) busyLast = i;
      if (mSClk && !prevSClk) begin
        riseCnt++;
        bits = {bits[14:0], sr[15]};
        if (lastShiftRel > 0 && (i - lastShiftRel) < minGap) minGap = i - lastShiftRel;
      end
      prevSClk = mSClk;
      if (i == startOff) start = 1'b0;
      if (i == p1 || i == p2) start = 1'b1;
      else if (i == p1 + 1 || i == p2 + 1) start = 1'b0;
    end
  endtask

  task automatic test_reset;
    Clr = 1'b1; start = 1'b0; sel = 1'b0;
    repeat (2) @(negedge Clk);
    nTotal++; if (aLoad !== 1'b0) $display("[TB] FAIL reset_load got %b want 0", aLoad); else nPass++;
    nTotal++; if (aShift !== 1'b0) $display("[TB] FAIL reset_shift got %b want 0", aShift); else nPass++;
    nTotal++; if (aSClk !== 1'b0) $display("[TB] FAIL reset_sclk got %b want 0", aSClk); else nPass++;
    nTotal++; if (aFrame !== 1'b0) $display("[TB] FAIL reset_frame got %b want 0", aFrame); else nPass++;
    nTotal++; if (aBusy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", aBusy); else nPass++;
    nTotal++; if (aDone !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", aDone); else nPass++;
    nTotal++; if ({bLoad, bShift, bSClk, bFrame, bBusy, bDone} !== 6'b0)
      $display("[TB] FAIL reset_b_outputs got %b want 000000", {bLoad, bShift, bSClk, bFrame, bBusy, bDone});
    else nPass++;
    Clr = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  // 8 bits x div 4: Load at 1, last HIGH at 1+128=129, Done at 130.
  task automatic test_nominal;
    sel = 1'b0;
    start = 1'b1;
    watch(140, 1, -1, -1);
    nTotal++; if (loadCnt !== 1) $display("[TB] FAIL nom_load_count got %0d want 1", loadCnt); else nPass++;
    nTotal++; if (loadRels.size() < 1 || loadRels[0] != 1) $display("[TB] FAIL nom_load_cycle got size %0d want cycle 1", loadRels.size()); else nPass++;
    nTotal++; if (riseCnt !== 16) $display("[TB] FAIL nom_sclk_rises got %0d want 16", riseCnt); else nPass++;
    nTotal++; if (shiftCnt !== 15) $display("[TB] FAIL nom_shifts got %0d want 15", shiftCnt); else nPass++;
    nTotal++; if (doneCnt !== 1) $display("[TB] FAIL nom_done_count got %0d want 1", doneCnt); else nPass++;
    nTotal++; if (doneRel !== 130) $display("[TB] FAIL nom_done_cycle got %0d want 130", doneRel); else nPass++;
    nTotal++; if (frameFirst !== 1) $display("[TB] FAIL nom_frame_first got %0d want 1", frameFirst); else nPass++;
    nTotal++; if (frameLast !== 129) $display("[TB] FAIL nom_frame_last got %0d want 129", frameLast); else nPass++;
    nTotal++; if (busyLast !== 130) $display("[TB] FAIL nom_busy_last got %0d want 130", busyLast); else nPass++;
    nTotal++; if (overlap !== 0) $display("[TB] FAIL nom_load_shift_overlap got %0d want 0", overlap); else nPass++;
    nTotal++; if (minGap < 3) $display("[TB] FAIL nom_shift_to_rise got %0d want >=3", minGap); else nPass++;
    nTotal++; if (bits !== 16'hA53C) $display("[TB] FAIL nom_serial_bits got %h want a53c", bits); else nPass++;
  endtask

  task automatic test_start_during_busy;
    sel = 1'b0;
    start = 1'b1;
    watch(300, 1, 10, 30);
    nTotal++; if (loadCnt !== 1) $display("[TB] FAIL busy_load_count got %0d want 1", loadCnt); else nPass++;
    nTotal++; if (doneCnt !== 1) $display("[TB] FAIL busy_done_count got %0d want 1", doneCnt); else nPass++;
    nTotal++; if (doneRel !== 130) $display("[TB] FAIL busy_done_cycle got %0d want 130", doneRel); else nPass++;
  endtask

  // Held Start: Done at 130, IDLE at 131, next Load at 132 -> spacing 131.
  task automatic test_back_to_back;
    sel = 1'b0;
    start = 1'b1;
    watch(300, 1000, -1, -1);
    start = 1'b0;
    nTotal++; if (loadCnt !== 3) $display("[TB] FAIL b2b_load_count got %0d want 3", loadCnt); else nPass++;
    nTotal++; if (loadRels.size() < 2 || (loadRels[1] - loadRels[0]) != 131)
      $display("[TB] FAIL b2b_load_spacing got size %0d want spacing 131", loadRels.size());
    else nPass++;
    nTotal++; if (doneCnt !== 2) $display("[TB] FAIL b2b_done_count got %0d want 2", doneCnt); else nPass++;
    repeat (200) @(negedge Clk);
    nTotal++; if (aBusy !== 1'b0) $display("[TB] FAIL b2b_idle_after got %b want 0", aBusy); else nPass++;
  endtask

  task automatic test_clear_mid_frame;
    sel = 1'b0;
    start = 1'b1;
    watch(20, 1, -1, -1);
    nTotal++; if (aFrame !== 1'b1) $display("[TB] FAIL clr_frame_active got %b want 1", aFrame); else nPass++;
    #1 Clr = 1'b1;
    #1;
    nTotal++; if ({aLoad, aShift, aSClk, aFrame, aBusy, aDone} !== 6'b0)
      $display("[TB] FAIL clr_async_outputs got %b want 000000", {aLoad, aShift, aSClk, aFrame, aBusy, aDone});
    else nPass++;
    @(negedge Clk);
    Clr = 1'b0;
    watch(150, 1000, -1, -1);
    nTotal++; if (doneCnt !== 0) $display("[TB] FAIL clr_no_done got %0d want 0", doneCnt); else nPass++;
    nTotal++; if (busyLast !== -1) $display("[TB] FAIL clr_stays_idle got %0d want -1", busyLast); else nPass++;
    start = 1'b1;
    watch(140, 1, -1, -1);
    nTotal++; if (doneRel !== 130) $display("[TB] FAIL clr_next_done got %0d want 130", doneRel); else nPass++;
    nTotal++; if (riseCnt !== 16) $display("[TB] FAIL clr_next_rises got %0d want 16", riseCnt); else nPass++;
  endtask

  // 1 bit x div 2: LOAD 1, LOW 2-3, HIGH 4-5, LOW 6-7 (Shift at 6), HIGH 8-9, DONE 10.
  task automatic test_min_divisor;
    sel = 1'b1;
    @(negedge Clk);
    start = 1'b1;
    watch(20, 1, -1, -1);
    nTotal++; if (loadRels.size() != 1 || loadRels[0] != 1) $display("[TB] FAIL min_load got count %0d want one at cycle 1", loadRels.size()); else nPass++;
    nTotal++; if (riseCnt !== 2) $display("[TB] FAIL min_sclk_rises got %0d want 2", riseCnt); else nPass++;
    nTotal++; if (shiftCnt !== 1) $display("[TB] FAIL min_shifts got %0d want 1", shiftCnt); else nPass++;
    nTotal++; if (doneRel !== 10) $display("[TB] FAIL min_done_cycle got %0d want 10", doneRel); else nPass++;
    nTotal++; if (frameLast !== 9) $display("[TB] FAIL min_frame_last got %0d want 9", frameLast); else nPass++;
    nTotal++; if (minGap < 1) $display("[TB] FAIL min_shift_to_rise got %0d want >=1", minGap); else nPass++;
    nTotal++; if (bits[1:0] !== 2'b10) $display("[TB] FAIL min_serial_bits got %b want 10", bits[1:0]); else nPass++;
    nTotal++; if (overlap !== 0) $display("[TB] FAIL min_load_shift_overlap got %0d want 0", overlap); else nPass++;
  endtask

  initial begin
    Clr = 1'b1;
    start = 1'b0;
    sel = 1'b0;
    test_reset;
    test_nominal;
    repeat (5) @(negedge Clk);
    test_start_during_busy;
    repeat (5) @(negedge Clk);
    test_back_to_back;
    test_clear_mid_frame;
    repeat (5) @(negedge Clk);
    test_min_divisor;
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
